// File: rtl/fir_mac_scheduler.sv
// ---------------------------------------------------------------------------
// fir_mac_scheduler
//
// Purpose:
//   Time-multiplexed FIR filter. It computes
//     y[n] = sum_{k=0}^{TAPS-1} c[k] * x[n-k]
//   with one shared multiplier and one accumulator, one tap per clock.
//   All arithmetic is unsigned and full precision, zero-extended to OUT_W.
//
//   The controller is a three-state FSM:
//     IDLE : waits for a sample and accepts coefficient writes
//     MAC  : one multiply-accumulate per cycle for taps 0..TAPS-1
//     OUT  : presents the result until the consumer takes it
//
//   Accept at edge t.
//   The result is visible after edge t+TAPS.
//   With out_ready=1, the handshake happens at edge t+TAPS+1.
//   The next sample can be accepted at edge t+TAPS+2, so the minimum
//   sample period is TAPS+2 cycles.
//
// Handshakes (valid/ready):
//   A transfer happens at a rising edge where valid && ready are both 1.
//   A producer holds its data stable while valid=1 and ready=0.
//   valid never depends combinationally on ready.
//   - input side  : in_valid / in_ready, data x_in
//                   (in_ready=1 only in IDLE after reset release)
//   - output side : out_valid / out_ready, data y_out
//                   (out_valid=1 only in OUT)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   x_in       in   sample data [DATA_W]
//   in_valid   in   x_in valid
//   in_ready   out  block can take a sample (IDLE only)
//   coef_we    in   coefficient write strobe
//   coef_addr  in   tap index to write [3]
//   coef_data  in   coefficient value [COEF_W]
//   coef_err   out  one-cycle pulse after a rejected coefficient write
//   y_out      out  filter result [OUT_W]; holds the last result
//   out_valid  out  y_out valid (OUT only)
//   out_ready  in   consumer takes y_out
//   busy       out  FSM not in IDLE
//   state_dbg  out  current FSM state encoding (0=IDLE, 1=MAC, 2=OUT)
// ---------------------------------------------------------------------------
module fir_mac_scheduler #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 3,
    parameter int OUT_W  = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] x_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              coef_we,
    input  logic [2:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_err,
    output logic [OUT_W-1:0]  y_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int MIN_OUT_W = PROD_W + $clog2(TAPS);
    localparam logic [2:0] LAST_K = 3'(TAPS - 1);

    // Reject parameter sets where the result cannot hold the full sum.
    generate
        if (TAPS < 2 || TAPS > 8 || OUT_W < MIN_OUT_W) begin : g_param_check
            $error("fir_mac_scheduler: illegal TAPS/OUT_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Storage is sized for the maximum tap count.
    // This lets the 3-bit tap index select exactly.
    // Entries at or above TAPS stay at zero and are never selected.
    logic [DATA_W-1:0] h [8];
    logic [COEF_W-1:0] c [8];

    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_next;
    logic [OUT_W-1:0]  y_reg;
    logic [2:0]        k;
    logic [PROD_W-1:0] prod;

    // alive is 0 during reset and rises at the first edge after release.
    // It keeps in_ready low while reset is asserted, even though the
    // FSM already sits in IDLE then.
    logic alive;
    logic coef_err_q;

    logic accept;
    logic mac_step;
    logic coef_ok;
    logic coef_bad;

    function automatic logic [COEF_W-1:0] coef_init(input int idx);
        case (idx)
            0:       return COEF_W'(3);
            1:       return COEF_W'(2);
            2:       return COEF_W'(1);
            default: return '0;
        endcase
    endfunction

    // The single shared multiplier.
    // Its operands are selected by the tap index.
    assign prod     = h[k] * c[k];
    assign acc_next = acc + OUT_W'(prod);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid && alive) state_next = S_MAC;
            S_MAC:  if (k == LAST_K)       state_next = S_OUT;
            S_OUT:  if (out_ready)         state_next = S_IDLE;
            default:                       state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs and datapath strobes
    // ---------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        mac_step  = 1'b0;
        coef_ok   = 1'b0;
        coef_bad  = 1'b0;
        state_dbg = state;
        case (state)
            S_IDLE: begin
                in_ready = alive;
                busy     = 1'b0;
                accept   = in_valid && alive;
                // Widened compare so that TAPS=8 does not wrap to 0.
                coef_ok  = coef_we && ({1'b0, coef_addr} < 4'(TAPS));
                coef_bad = coef_we && !({1'b0, coef_addr} < 4'(TAPS));
            end
            S_MAC: begin
                mac_step = 1'b1;
                coef_bad = coef_we;
            end
            S_OUT: begin
                out_valid = 1'b1;
                coef_bad  = coef_we;
            end
            default: begin
                coef_bad = coef_we;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath: history, coefficients, accumulator, result
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive      <= 1'b0;
            acc        <= '0;
            k          <= '0;
            y_reg      <= '0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h[i] <= '0;
                c[i] <= coef_init(i);
            end
        end else begin
            alive      <= 1'b1;
            coef_err_q <= coef_bad;

            // A write that lands with an accept is visible at the first
            // MAC cycle, so the accepted sample uses the new value.
            if (coef_ok) begin
                c[coef_addr] <= coef_data;
            end

            if (accept) begin
                h[0] <= x_in;
                for (int i = 1; i < 8; i++) begin
                    if (i < TAPS) begin
                        h[i] <= h[i-1];
                    end
                end
                acc <= '0;
                k   <= '0;
            end else if (mac_step) begin
                acc <= acc_next;
                if (k == LAST_K) begin
                    // Capture the finished sum.
                    // y_out then holds it through OUT and after the
                    // handshake.
                    y_reg <= acc_next;
                    k     <= '0;
                end else begin
                    k <= k + 3'd1;
                end
            end
        end
    end

    assign y_out    = y_reg;
    assign coef_err = coef_err_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_scheduler
//
// Self-checking bench for fir_mac_scheduler (TAPS=3).
//
// Inputs are driven and outputs are sampled on the falling edge.
// Each rising edge therefore sees stable inputs.
//
// A small reference model supplies the expected sums:
//   - a coefficient array
//   - a history shift register
// Expected results are queued when a sample is accepted.
// They are popped when the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_fir_mac_scheduler;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 3;
    localparam int OUT_W  = 18;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] x_in;
    logic              in_valid;
    logic              in_ready;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              coef_err;
    logic [OUT_W-1:0]  y_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [1:0]        state_dbg;

    always #5 clk = ~clk;

    fir_mac_scheduler #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .TAPS  (TAPS),
        .OUT_W (OUT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x_in     (x_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .coef_err (coef_err),
        .y_out    (y_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int tick_n = 0;
    logic [OUT_W-1:0] exp_q[$];
    int unsigned mc[8];
    int unsigned mh[8];

    typedef struct {
        logic [DATA_W-1:0] x;
        logic [OUT_W-1:0]  exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        tick_n++;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            mh[i] = 0;
            mc[i] = 0;
        end
        mc[0] = 3;
        mc[1] = 2;
        mc[2] = 1;
    endfunction

    function automatic logic [OUT_W-1:0] model_accept(input int unsigned x);
        longint unsigned sum = 0;
        for (int i = TAPS - 1; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = x;
        for (int i = 0; i < TAPS; i++) sum += longint'(mc[i]) * longint'(mh[i]);
        return OUT_W'(sum);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pop_check(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s actual=%0d expected=<none queued>", name, y_out);
        end else begin
            logic [OUT_W-1:0] e;
            e = exp_q.pop_front();
            checks--;
            check(name, y_out, e);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check({name, "_ready_timeout"}, in_ready, 1);
    endtask

    // Waits for out_valid (out_ready assumed 1).
    // Checks the result and completes the handshake.
    // Returns the number of edges from the accept edge to the handshake edge.
    task automatic wait_and_pop(input string name, input int lat0, output int lat);
        lat = lat0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        if (!out_valid) check({name, "_out_timeout"}, out_valid, 1);
        pop_check(name);
        tick();
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_ready_back"}, in_ready, 1);
        lat = lat + 1;
    endtask

    task automatic send(input logic [DATA_W-1:0] x, input logic [OUT_W-1:0] exp,
                        input string name);
        int lat;
        wait_ready(name);
        in_valid = 1'b1;
        x_in     = x;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        wait_and_pop(name, 0, lat);
        check({name, "_lat"}, lat, TAPS + 1);
    endtask

    task automatic coef_write(input logic [2:0] addr, input logic [COEF_W-1:0] data,
                              input logic exp_err, input string name);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        if (!exp_err) mc[addr] = data;
        tick();
        coef_we = 1'b0;
        check({name, "_err"}, coef_err, exp_err);
        tick();
        check({name, "_err_clear"}, coef_err, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        tick();
    endtask

    // ---------------- test ----------------
    initial begin
        logic [OUT_W-1:0] e;
        int lat;
        int acc_ticks[$];

        reset     = 1'b0;
        x_in      = '0;
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        out_ready = 1'b1;
        model_reset();

        tbl[0] = '{x: 8'd10, exp: 18'd30};
        tbl[1] = '{x: 8'd20, exp: 18'd80};
        tbl[2] = '{x: 8'd30, exp: 18'd140};
        tbl[3] = '{x: 8'd0,  exp: 18'd80};
        tbl[4] = '{x: 8'd7,  exp: 18'd51};

        // Reset state.
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_y_out", y_out, 0);
        check("rst_coef_err", coef_err, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b1;
        tick();
        check("ready_after_release", in_ready, 1);

        // Table-driven vectors with default coefficients.
        for (int i = 0; i < 5; i++) begin
            void'(model_accept(tbl[i].x));
            send(tbl[i].x, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Back-pressure: hold out_ready low for 5 cycles in OUT.
        out_ready = 1'b0;
        e = model_accept(4);
        wait_ready("bp");
        in_valid = 1'b1;
        x_in     = 8'd4;
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("bp_out_valid", out_valid, 1);
        in_valid = 1'b1;
        x_in     = 8'd99;
        for (int i = 0; i < 5; i++) begin
            check("bp_y_stable", y_out, e);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
            check("bp_state", state_dbg, 2);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pop_check("bp_y");
        tick();
        check("bp_valid_drop", out_valid, 0);
        // If the held 99 had been consumed, this sum would differ.
        send(8'd1, model_accept(1), "bp_after");

        // Coefficient write rules.
        do_reset();
        wait_ready("cw_mac");
        in_valid = 1'b1;
        x_in     = 8'd2;
        exp_q.push_back(model_accept(2));
        tick();
        in_valid  = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 8'd100;
        tick();
        coef_we = 1'b0;
        check("cw_mac_err", coef_err, 1);
        check("cw_mac_busy", busy, 1);
        tick();
        check("cw_mac_err_clear", coef_err, 0);
        wait_and_pop("cw_mac_y", 2, lat);
        send(8'd3, 18'd13, "cw_unchanged");
        void'(model_accept(3));
        coef_write(3'd5, 8'd50, 1'b1, "cw_addr5");
        coef_write(3'd3, 8'd50, 1'b1, "cw_addr3");
        wait_ready("cw_accept");
        coef_we   = 1'b1;
        coef_addr = 3'd1;
        coef_data = 8'd10;
        mc[1]     = 10;
        in_valid  = 1'b1;
        x_in      = 8'd1;
        exp_q.push_back(model_accept(1));
        tick();
        coef_we  = 1'b0;
        in_valid = 1'b0;
        check("cw_accept_err", coef_err, 0);
        wait_and_pop("cw_accept_y", 1, lat);
        check("cw_accept_model", mc[1], 10);

        // Full-scale values.
        do_reset();
        coef_write(3'd0, 8'd255, 1'b0, "fs_c0");
        coef_write(3'd1, 8'd255, 1'b0, "fs_c1");
        coef_write(3'd2, 8'd255, 1'b0, "fs_c2");
        void'(model_accept(255));
        send(8'd255, 18'd65025, "fs_y0");
        void'(model_accept(255));
        send(8'd255, 18'd130050, "fs_y1");
        void'(model_accept(255));
        send(8'd255, 18'd195075, "fs_y2");

        // Reset in the middle of MAC.
        wait_ready("rm");
        in_valid = 1'b1;
        x_in     = 8'd50;
        tick();
        in_valid = 1'b0;
        tick();
        check("rm_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("rm_async_busy", busy, 0);
        check("rm_async_y", y_out, 0);
        check("rm_async_in_ready", in_ready, 0);
        check("rm_async_out_valid", out_valid, 0);
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        tick();
        check("rm_ready_after", in_ready, 1);
        void'(model_accept(5));
        send(8'd5, 18'd15, "rm_y");

        // Throughput with random coefficients and samples.
        for (int i = 0; i < TAPS; i++) begin
            coef_write(3'(i), 8'($urandom_range(0, 255)), 1'b0, "tp_coef");
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x_in      = 8'($urandom_range(0, 255));
        for (int i = 0; i < 42; i++) begin
            if (out_valid) pop_check("tp_y");
            if (in_ready) begin
                acc_ticks.push_back(tick_n);
                exp_q.push_back(model_accept(x_in));
            end
            tick();
            x_in = 8'($urandom_range(0, 255));
        end
        in_valid = 1'b0;
        lat = 0;
        while (exp_q.size() > 0 && lat < 60) begin
            if (out_valid) pop_check("tp_drain_y");
            tick();
            lat++;
        end
        check("tp_drained", exp_q.size(), 0);
        check("tp_accepts", acc_ticks.size() >= 8, 1);
        for (int i = 1; i < acc_ticks.size(); i++) begin
            check("tp_period", acc_ticks[i] - acc_ticks[i-1], TAPS + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
